// File: rtl/wb_addr_dec.sv
// Wishbone classic address decoder / response mux: request to slave strobe in 1 cycle, slave ack to ack_o in 1 cycle.
// No backpressure of its own: the master waits for ack_o/err_o; unmapped or hung accesses end in err_o.
module wb_addr_dec #(
  parameter int                 NSLV     = 4,
  parameter int                 AW       = 30,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int                 TW       = 8,
  parameter int                 TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [DW/8-1:0]      sel_i,
  input  logic [AW-1:0]        adr_i,
  input  logic [DW-1:0]        dat_i,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [DW-1:0]        dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  output logic                 flt_valid_o,
  output logic [AW-1:0]        flt_adr_o,
  output logic                 flt_tmo_o,
  input  logic                 flt_clr_i
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [NSLV-1:0] sel_q;
  logic [TW-1:0]   cnt_q;
  logic [NSLV-1:0] hit_oh;
  logic            hit;
  logic [DW-1:0]   sel_dat;
  logic            sel_ack;
  logic            tmo_hit;
  logic            go, ack_d, err_d, unmapped, tmo_flt, fault;

  // Lowest-index matching region wins when regions overlap.
  always_comb begin
    hit_oh = '0;
    hit    = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && (((adr_i ^ SLV_BASE[i*AW +: AW]) & SLV_MASK[i*AW +: AW]) == '0)) begin
        hit_oh[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) sel_dat = s_dat_i[i*DW +: DW];
    end
  end

  assign sel_ack = |(s_ack_i & sel_q);
  assign tmo_hit = (cnt_q == TW'(TIMEOUT - 1));
  assign fault   = unmapped | tmo_flt;

  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    unmapped = 1'b0;
    tmo_flt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          if (hit) begin
            go      = 1'b1;
            state_d = ACTIVE;
          end else begin
            err_d    = 1'b1;
            unmapped = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A master abort takes precedence: nobody is left to receive a response.
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          tmo_flt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_cyc_o = (state_q == ACTIVE) ? sel_q : '0;
  assign s_stb_o = (state_q == ACTIVE) ? sel_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      dat_o       <= '0;
      s_we_o      <= 1'b0;
      s_sel_o     <= '0;
      s_adr_o     <= '0;
      s_dat_o     <= '0;
      flt_valid_o <= 1'b0;
      flt_adr_o   <= '0;
      flt_tmo_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_o   <= ack_d;
      err_o   <= err_d;
      if (go) begin
        sel_q   <= hit_oh;
        s_we_o  <= we_i;
        s_sel_o <= sel_i;
        s_adr_o <= adr_i;
        s_dat_o <= dat_i;
        cnt_q   <= '0;
      end else if (state_q == ACTIVE && cnt_q != '1) begin
        cnt_q <= cnt_q + TW'(1);
      end
      if (ack_d) dat_o <= sel_dat;
      // First fault sticks; a clear coinciding with a new fault still captures it.
      if (fault && (!flt_valid_o || flt_clr_i)) begin
        flt_valid_o <= 1'b1;
        flt_adr_o   <= unmapped ? adr_i : s_adr_o;
        flt_tmo_o   <= tmo_flt;
      end else if (flt_clr_i) begin
        flt_valid_o <= 1'b0;
      end
    end
  end

endmodule
